free_list: RTL and testbench

Circular FIFO of free physical register indices feeding rename/dispatch. Responds to `pop_free_list` with SS fresh destination tags, registered on `free_list_regs` and valid the cycle after the pop. This matches dispatch's one-cycle `avail_inst` delay. Accepts SS released tags per cycle from ROB commit, which are the stale physical mappings of retiring instructions.

---
 rtl/free_list.sv | 109 ++++++++++
 tb/tb_free_list.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags for rename/dispatch: SS pops and SS pushes per cycle.
// Optional checkpoint restore of the read pointer is enabled by defining FREE_LIST_FLUSH_EN.
module free_list #(
    parameter int SS         = 2,
    parameter int PR_ENTRIES = 64,
    parameter int ARCH_REGS  = 32,
    localparam int DEPTH     = PR_ENTRIES - ARCH_REGS,
    localparam int PTR_W     = $clog2(DEPTH) + 1,
    localparam int IDX_W     = $clog2(PR_ENTRIES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pop_free_list,
    output logic [SS-1:0][IDX_W-1:0]    free_list_regs,
    output logic                        can_pop,
    input  logic [SS-1:0]               push_en,
    input  logic [SS-1:0][IDX_W-1:0]    push_regs,
    output logic [PTR_W-1:0]            count,
    output logic [PTR_W-1:0]            head_ptr,
`ifdef FREE_LIST_FLUSH_EN
    input  logic                        flush,
    input  logic [PTR_W-1:0]            flush_head,
`endif
    output logic                        overflow
);

    logic [IDX_W-1:0]          mem [DEPTH];
    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;

    logic                      pop_ok;
    logic [PTR_W-1:0]          rd_ptr;
    logic [SS-1:0][IDX_W-1:0]  rd_data;
    logic [PTR_W:0]            room;
    logic [PTR_W-1:0]          n_push;
    logic [PTR_W-1:0]          wr_ptr;
    logic                      ovf_now;
    logic [SS-1:0]             wr_en;
    logic [PTR_W-2:0]          wr_idx  [SS];
    logic [IDX_W-1:0]          wr_data [SS];

    assign count    = tail - head;
    assign can_pop  = (count >= PTR_W'(SS));
    assign head_ptr = head;

    always_comb begin
        pop_ok  = pop_free_list && (count >= PTR_W'(SS));
`ifdef FREE_LIST_FLUSH_EN
        if (flush) pop_ok = 1'b0;
`endif
        rd_ptr  = '0;
        rd_data = '0;
        for (int k = 0; k < SS; k++) begin
            rd_ptr     = head + PTR_W'(k);
            rd_data[k] = mem[rd_ptr[PTR_W-2:0]];
        end

        // Free slots this cycle include the ones vacated by an accepted pop
        room    = (PTR_W+1)'(DEPTH) - {1'b0, count} + (pop_ok ? (PTR_W+1)'(SS) : '0);
        n_push  = '0;
        wr_ptr  = '0;
        ovf_now = 1'b0;
        wr_en   = '0;
        for (int k = 0; k < SS; k++) begin
            wr_idx[k]  = '0;
            wr_data[k] = '0;
        end
        for (int k = 0; k < SS; k++) begin
            if (push_en[k] && (push_regs[k] != '0)) begin
                if ({1'b0, n_push} < room) begin
                    wr_ptr     = tail + n_push;
                    wr_en[k]   = 1'b1;
                    wr_idx[k]  = wr_ptr[PTR_W-2:0];
                    wr_data[k] = push_regs[k];
                    n_push     = n_push + PTR_W'(1);
                end else begin
                    ovf_now = 1'b1;
                end
            end
        end
    end

    // Tail starts with its wrap bit set so the list comes up full of tags ARCH_REGS..PR_ENTRIES-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= IDX_W'(ARCH_REGS + i);
            end
            head           <= '0;
            tail           <= {1'b1, {(PTR_W-1){1'b0}}};
            free_list_regs <= '0;
            overflow       <= 1'b0;
        end else begin
            if (pop_ok) begin
                free_list_regs <= rd_data;
                head           <= head + PTR_W'(SS);
            end
`ifdef FREE_LIST_FLUSH_EN
            if (flush) head <= flush_head;
`endif
            tail <= tail + n_push;
            for (int k = 0; k < SS; k++) begin
                if (wr_en[k]) mem[wr_idx[k]] <= wr_data[k];
            end
            if (ovf_now) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a queue model predicts popped tags, count, head and overflow.
module tb_free_list;
    localparam int SS         = 2;
    localparam int PR_ENTRIES = 64;
    localparam int ARCH_REGS  = 32;
    localparam int DEPTH      = 32;
    localparam int PTR_W      = 6;
    localparam int IDX_W      = 6;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic                       pop_free_list = 1'b0;
    logic [SS-1:0][IDX_W-1:0]   free_list_regs;
    logic                       can_pop;
    logic [SS-1:0]              push_en = '0;
    logic [SS-1:0][IDX_W-1:0]   push_regs = '0;
    logic [PTR_W-1:0]           count;
    logic [PTR_W-1:0]           head_ptr;
    logic                       overflow;
`ifdef FREE_LIST_FLUSH_EN
    logic                       flush = 1'b0;
    logic [PTR_W-1:0]           flush_head = '0;
`endif

    int total = 0;
    int bad = 0;
    int model_q[$];
    int exp_q[$];
    int exp_last[SS];
    int exp_head;
    bit exp_ovf;

    free_list #(.SS(SS), .PR_ENTRIES(PR_ENTRIES), .ARCH_REGS(ARCH_REGS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pop_free_list(pop_free_list),
        .free_list_regs(free_list_regs),
        .can_pop(can_pop),
        .push_en(push_en),
        .push_regs(push_regs),
        .count(count),
        .head_ptr(head_ptr),
`ifdef FREE_LIST_FLUSH_EN
        .flush(flush),
        .flush_head(flush_head),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model_q.push_back(ARCH_REGS + i);
        for (int k = 0; k < SS; k++) exp_last[k] = 0;
        exp_head = 0;
        exp_ovf  = 1'b0;
    endtask

    task automatic check_all();
        check_output("regs0", 32'(free_list_regs[0]), exp_last[0]);
        check_output("regs1", 32'(free_list_regs[1]), exp_last[1]);
        check_output("count", 32'(count), model_q.size());
        check_output("can_pop", 32'(can_pop), (model_q.size() >= SS) ? 1 : 0);
        check_output("head_ptr", 32'(head_ptr), exp_head);
        check_output("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    // Model order: accepted pop leaves the queue first, then valid lanes append while room remains
    task automatic apply_stimulus(input bit pop, input logic [SS-1:0] en, input int r0, input int r1);
        int r[SS];
        r[0] = r0;
        r[1] = r1;
        pop_free_list = pop;
        push_en       = en;
        push_regs[0]  = IDX_W'(r0);
        push_regs[1]  = IDX_W'(r1);
        if (pop && model_q.size() >= SS) begin
            for (int k = 0; k < SS; k++) exp_q.push_back(model_q.pop_front());
            exp_head = (exp_head + SS) % 64;
        end
        for (int k = 0; k < SS; k++) begin
            if (en[k] && r[k] != 0) begin
                if (model_q.size() < DEPTH) model_q.push_back(r[k]);
                else exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        pop_free_list = 1'b0;
        push_en       = '0;
        if (exp_q.size() >= SS) begin
            for (int k = 0; k < SS; k++) exp_last[k] = exp_q.pop_front();
        end
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        model_reset();
        check_output("rst_count", 32'(count), DEPTH);
        check_output("rst_head", 32'(head_ptr), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

`ifdef FREE_LIST_FLUSH_EN
    task automatic flush_step(input logic [PTR_W-1:0] fh);
        flush         = 1'b1;
        flush_head    = fh;
        pop_free_list = 1'b1;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        pop_free_list = 1'b0;
        model_q.delete();
        for (int i = 0; i < DEPTH; i++) model_q.push_back(ARCH_REGS + i);
        exp_head = 0;
        check_all();
    endtask
`endif

    initial begin
        model_reset();
        #1;
        do_reset();

        // Drain the list, then pop while empty
        repeat (16) apply_stimulus(1'b1, 2'b00, 0, 0);
        apply_stimulus(1'b1, 2'b00, 0, 0);

        apply_stimulus(1'b0, 2'b11, 5, 9);
        apply_stimulus(1'b1, 2'b00, 0, 0);

        // Refill across the index wrap, then drain in order
        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 2'b11, 10 + 2*i, 11 + 2*i);
        repeat (16) apply_stimulus(1'b1, 2'b00, 0, 0);

        do_reset();
        apply_stimulus(1'b0, 2'b01, 0, 0);
        apply_stimulus(1'b0, 2'b11, 7, 0);

`ifdef FREE_LIST_FLUSH_EN
        do_reset();
        repeat (3) apply_stimulus(1'b1, 2'b00, 0, 0);
        flush_step('0);
        apply_stimulus(1'b1, 2'b00, 0, 0);
`endif

        // Mixed simultaneous traffic
        do_reset();
        repeat (12) apply_stimulus(1'b1, 2'b00, 0, 0);
        for (int i = 0; i < 80; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
